// File: rtl/ram_sdp_port_arbiter_if.sv
// Client-side bundle for ram_sdp_port_arbiter: packed per-requester write/read
// requests, one-hot accepts and the shared read-response bus.
interface ram_sdp_port_arbiter_if #(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 9
);
    logic [NumPorts-1:0]           wr_valid;
    logic [NumPorts*AddrWidth-1:0] wr_addr;
    logic [NumPorts*32-1:0]        wr_data;
    logic [NumPorts-1:0]           wr_ready;
    logic [NumPorts-1:0]           rd_valid;
    logic [NumPorts*AddrWidth-1:0] rd_addr;
    logic [NumPorts-1:0]           rd_ready;
    logic [NumPorts-1:0]           rsp_valid;
    logic [31:0]                   rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_sdp_port_arbiter.sv
// Round-robin sharing of one SDP BRAM between NumPorts requesters, write and read arbitrated independently.
// Latency: accept in the request cycle; read response exactly ReadLatency cycles after rd_ready.
// Backpressure: requests hold valid until ready; responses have none and must be sunk.
module ram_sdp_port_arbiter #(
    parameter int NumPorts    = 4,
    parameter int AddrWidth   = 9,
    parameter int ReadLatency = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ram_sdp_port_arbiter_if.slave port,
    output logic                 mem_wr_en,
    output logic [AddrWidth-1:0] mem_wr_addr,
    output logic [31:0]          mem_wr_data,
    output logic                 mem_rd_en,
    output logic [AddrWidth-1:0] mem_rd_addr,
    input  logic [31:0]          mem_rd_data,
    output logic [15:0]          collision_cnt
);
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          wr_pick, rd_pick;
    logic                 wr_gnt, rd_cand, rd_gnt, collide;
    logic [PW-1:0]        wr_idx, rd_idx;
    logic [AddrWidth-1:0] rd_cand_addr;
    logic                 pipe_vld [ReadLatency];
    logic [PW-1:0]        pipe_tag [ReadLatency];

    // Returns {found, index}: first request at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [NumPorts-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NumPorts;
            if (req[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NumPorts - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_pick       = rr_pick(port.wr_valid, wr_ptr);
        rd_pick       = rr_pick(port.rd_valid, rd_ptr);
        wr_gnt        = wr_pick[PW];
        wr_idx        = wr_pick[PW-1:0];
        rd_cand       = rd_pick[PW];
        rd_idx        = rd_pick[PW-1:0];
        mem_wr_addr   = '0;
        mem_wr_data   = '0;
        rd_cand_addr  = '0;
        port.wr_ready = '0;
        port.rd_ready = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (wr_gnt && wr_idx == PW'(i)) begin
                mem_wr_addr = port.wr_addr[i*AddrWidth +: AddrWidth];
                mem_wr_data = port.wr_data[i*32 +: 32];
            end
            if (rd_cand && rd_idx == PW'(i)) rd_cand_addr = port.rd_addr[i*AddrWidth +: AddrWidth];
        end
        // A read racing a write to the same word waits; no other reader takes its slot.
        collide     = wr_gnt && rd_cand && (rd_cand_addr == mem_wr_addr);
        rd_gnt      = rd_cand && !collide;
        mem_wr_en   = wr_gnt;
        mem_rd_en   = rd_gnt;
        mem_rd_addr = rd_gnt ? rd_cand_addr : '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (wr_gnt && wr_idx == PW'(i)) port.wr_ready[i] = 1'b1;
            if (rd_gnt && rd_idx == PW'(i)) port.rd_ready[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            collision_cnt <= '0;
        end else begin
            if (wr_gnt) wr_ptr <= next_ptr(wr_idx);
            if (rd_gnt) rd_ptr <= next_ptr(rd_idx);
            if (collide && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
        end
    end

    // Tag pipeline mirrors the RAM read latency so data and owner line up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_gnt;
            pipe_tag[0] <= rd_idx;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_comb begin
        port.rsp_valid = '0;
        port.rsp_data  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (pipe_vld[ReadLatency-1] && pipe_tag[ReadLatency-1] == PW'(i)) port.rsp_valid[i] = 1'b1;
        end
        if (pipe_vld[ReadLatency-1]) port.rsp_data = mem_rd_data;
    end
endmodule

// File: tb/tb_ram_sdp_port_arbiter.sv
// Directed bench for ram_sdp_port_arbiter with a 2-cycle behavioural SDP RAM.
module tb_ram_sdp_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [31:0]   mem_wr_data, mem_rd_data;
    logic [15:0]   collision_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    ram_sdp_port_arbiter_if #(.NumPorts(NP), .AddrWidth(AW)) bus ();

    ram_sdp_port_arbiter #(.NumPorts(NP), .AddrWidth(AW), .ReadLatency(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .port         (bus),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:511];
    logic [31:0] rd_q0, rd_q1;
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) rd_q0 <= ram[mem_rd_addr];
        rd_q1 <= rd_q0;
    end
    assign mem_rd_data = rd_q1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_valid = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = '0;
        bus.rd_addr  = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        bus.wr_valid[p]        = 1'b1;
        bus.wr_addr[p*AW +: AW] = a;
        bus.wr_data[p*32 +: 32] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.wr_ready[p]) got = 1;
            next_cycle();
        end
        bus.wr_valid[p] = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL do_write_timeout port=%0d got no wr_ready within 20 cycles", p);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #2;
        tests_run++;
        if ({bus.wr_ready, bus.rd_ready, bus.rsp_valid} !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_ready_rsp got=%h want=000", {bus.wr_ready, bus.rd_ready, bus.rsp_valid});
        end
        tests_run++;
        if (collision_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_collision_cnt got=%h want=0000", collision_cnt);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_wr_en, mem_rd_en} !== 2'b00 || mem_wr_addr !== '0 || mem_rd_addr !== '0 || mem_wr_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_mem_pins got en=%b wa=%h ra=%h wd=%h want all 0", {mem_wr_en, mem_rd_en}, mem_wr_addr, mem_rd_addr, mem_wr_data);
        end
        tests_run++;
        if (bus.rsp_data !== 32'h0 || bus.rsp_valid !== 4'h0 || bus.wr_ready !== 4'h0 || bus.rd_ready !== 4'h0) begin
            tests_failed++;
            $display("FAIL idle_bus got rsp_data=%h rsp_valid=%b want 0", bus.rsp_data, bus.rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_write_then_read();
        apply_reset();
        bus.wr_valid[2]      = 1'b1;
        bus.wr_addr[2*AW +: AW] = 9'h05;
        bus.wr_data[2*32 +: 32] = 32'hDEADBEEF;
        @(negedge clk);
        tests_run++;
        if (bus.wr_ready !== 4'b0100 || mem_wr_en !== 1'b1 || mem_wr_addr !== 9'h05 || mem_wr_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_grant got ready=%b en=%b addr=%h data=%h want 0100 1 005 deadbeef", bus.wr_ready, mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        next_cycle();
        bus.wr_valid[2]      = 1'b0;
        bus.rd_valid[1]      = 1'b1;
        bus.rd_addr[1*AW +: AW] = 9'h05;
        @(negedge clk);
        tests_run++;
        if (bus.rd_ready !== 4'b0010 || mem_rd_en !== 1'b1 || mem_rd_addr !== 9'h05) begin
            tests_failed++;
            $display("FAIL rd_grant got ready=%b en=%b addr=%h want 0010 1 005", bus.rd_ready, mem_rd_en, mem_rd_addr);
        end
        next_cycle();
        bus.rd_valid[1] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rsp_early got=%b want=0000", bus.rsp_valid);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_rd_rsp got valid=%b data=%h want 0010 deadbeef", bus.rsp_valid, bus.rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_round_robin_reads();
        for (int i = 0; i < 4; i++) do_write(0, 9'(16 + i), 32'hA0 + 32'(i));
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            for (int p = 0; p < NP; p++) begin
                bus.rd_valid[p]         = (c < 5);
                bus.rd_addr[p*AW +: AW] = 9'(16 + p);
            end
            @(negedge clk);
            tests_run++;
            if (c < 5 && (bus.rd_ready !== 4'(1 << (c % 4)) || mem_rd_addr !== 9'(16 + c % 4))) begin
                tests_failed++;
                $display("FAIL rr_grant c=%0d got ready=%b addr=%h want %b %h", c, bus.rd_ready, mem_rd_addr, 4'(1 << (c % 4)), 9'(16 + c % 4));
            end else if (c >= 5 && bus.rd_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_idle c=%0d got ready=%b want 0000", c, bus.rd_ready);
            end
            if (c >= 2) begin
                tests_run++;
                if (bus.rsp_valid !== 4'(1 << ((c - 2) % 4)) || bus.rsp_data !== 32'hA0 + 32'((c - 2) % 4)) begin
                    tests_failed++;
                    $display("FAIL rr_rsp c=%0d got valid=%b data=%h want %b %h", c, bus.rsp_valid, bus.rsp_data, 4'(1 << ((c - 2) % 4)), 32'hA0 + 32'((c - 2) % 4));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_collision();
        apply_reset();
        bus.wr_valid[0]         = 1'b1;
        bus.wr_addr[0 +: AW]    = 9'h20;
        bus.wr_data[0 +: 32]    = 32'h12345678;
        bus.rd_valid[3]         = 1'b1;
        bus.rd_addr[3*AW +: AW] = 9'h20;
        @(negedge clk);
        tests_run++;
        if (bus.wr_ready !== 4'b0001 || bus.rd_ready !== 4'b0000 || mem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_defer got wr=%b rd=%b rd_en=%b want 0001 0000 0", bus.wr_ready, bus.rd_ready, mem_rd_en);
        end
        next_cycle();
        bus.wr_valid[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.rd_ready !== 4'b1000 || collision_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL coll_retry got rd=%b cnt=%0d want 1000 1", bus.rd_ready, collision_cnt);
        end
        next_cycle();
        bus.rd_valid[3] = 1'b0;
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL coll_rsp got valid=%b data=%h want 1000 12345678", bus.rsp_valid, bus.rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_wr_ptr_wrap();
        apply_reset();
        do_write(1, 9'h50, 32'h1);
        bus.wr_valid[1]         = 1'b1;
        bus.wr_addr[1*AW +: AW] = 9'h30;
        bus.wr_data[1*32 +: 32] = 32'h11;
        bus.wr_valid[3]         = 1'b1;
        bus.wr_addr[3*AW +: AW] = 9'h31;
        bus.wr_data[3*32 +: 32] = 32'h33;
        bus.rd_valid[1]         = 1'b1;
        bus.rd_addr[1*AW +: AW] = 9'h40;
        @(negedge clk);
        tests_run++;
        if (bus.wr_ready !== 4'b1000 || mem_wr_addr !== 9'h31 || bus.rd_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL ptr_first got wr=%b addr=%h rd=%b want 1000 031 0010", bus.wr_ready, mem_wr_addr, bus.rd_ready);
        end
        next_cycle();
        bus.wr_valid[3] = 1'b0;
        bus.rd_valid[1] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.wr_ready !== 4'b0010 || mem_wr_addr !== 9'h30 || mem_wr_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL ptr_second got wr=%b addr=%h data=%h want 0010 030 00000011", bus.wr_ready, mem_wr_addr, mem_wr_data);
        end
        next_cycle();
        bus.wr_valid[1] = 1'b0;
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        bus.rd_valid[0]         = 1'b1;
        bus.rd_addr[0 +: AW]    = 9'h10;
        bus.rd_valid[1]         = 1'b1;
        bus.rd_addr[1*AW +: AW] = 9'h11;
        @(negedge clk);
        tests_run++;
        if (bus.rd_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL burst_rd0 got=%b want=0001", bus.rd_ready);
        end
        next_cycle();
        bus.rd_valid[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.rd_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL burst_rd1 got=%b want=0010", bus.rd_ready);
        end
        next_cycle();
        reset_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.rsp_valid !== 4'b0000) begin
                tests_failed++;
                $display("FAIL burst_flush i=%0d got=%b want=0000", i, bus.rsp_valid);
            end
            next_cycle();
            if (i == 1) reset_n = 1'b1;
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.wr_valid[0]         = 1'b1;
        bus.wr_addr[0 +: AW]    = 9'h77;
        bus.wr_data[0 +: 32]    = 32'h5;
        bus.rd_valid[1]         = 1'b1;
        bus.rd_addr[1*AW +: AW] = 9'h77;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (collision_cnt !== 16'hFFFE || bus.rd_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sat_pre got cnt=%h rd=%b want fffe 0000", collision_cnt, bus.rd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (collision_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach got=%h want=ffff", collision_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (collision_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold got=%h want=ffff", collision_cnt);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_round_robin_reads();
        test_collision();
        test_wr_ptr_wrap();
        test_reset_midburst();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
